// File: rtl/maxpool_2x2_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : maxpool_2x2_stage_pkg                                  |
// | Brief   : Shared defaults and FSM state encoding for the 2x2     |
// |           max-pooling stage.                                     |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package maxpool_2x2_stage_pkg;

  localparam int c_N_C_DEFAULT    = 26;
  localparam int c_N_R_DEFAULT    = 26;
  localparam int c_DATA_W_DEFAULT = 8;
  localparam int c_ADDR_W_DEFAULT = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_EMIT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/maxpool_2x2_stage_window_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : pool_window_counter                                    |
// | Brief   : Walks the pooled window grid (i = pooled row, j =      |
// |           pooled column) and flags the final window of the map.  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module pool_window_counter #(
  parameter int N_C    = 26,
  parameter int N_R    = 26,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  output logic [ADDR_W-1:0] i,
  output logic [ADDR_W-1:0] j,
  output logic              last
);

  localparam logic [ADDR_W-1:0] c_J_LAST = ADDR_W'(N_C / 2 - 1);
  localparam logic [ADDR_W-1:0] c_I_LAST = ADDR_W'(N_R / 2 - 1);

  logic [ADDR_W-1:0] r_i;
  logic [ADDR_W-1:0] r_j;

  assign i    = r_i;
  assign j    = r_j;
  assign last = (r_i == c_I_LAST) && (r_j == c_J_LAST);

  // Raster-order window stepping; the final window wraps back to (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i <= '0;
      r_j <= '0;
    end else if (clear) begin
      r_i <= '0;
      r_j <= '0;
    end else if (step) begin
      if (r_j == c_J_LAST) begin
        r_j <= '0;
        r_i <= last ? '0 : r_i + 1'b1;
      end else begin
        r_j <= r_j + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/maxpool_2x2_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : maxpool_2x2_stage                                      |
// | Brief   : Reads a conv feature map window by window (TL,TR,BL,BR)|
// |           and emits the signed 2x2 maximum with a valid/ready    |
// |           handshake.                                             |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module maxpool_2x2_stage
  import maxpool_2x2_stage_pkg::*;
#(
  parameter int N_C    = c_N_C_DEFAULT,
  parameter int N_R    = c_N_R_DEFAULT,
  parameter int DATA_W = c_DATA_W_DEFAULT,
  parameter int ADDR_W = c_ADDR_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic        [ADDR_W-1:0] rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic signed [DATA_W-1:0] pool_data,
  output logic        [ADDR_W-1:0] pool_addr,
  output logic                     pool_valid,
  input  logic                     pool_ready,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ADDR_W-1:0] c_NC     = ADDR_W'(N_C);
  localparam logic [ADDR_W-1:0] c_HALF_C = ADDR_W'(N_C / 2);

  // Elaboration-time guard: the largest read address must fit rd_addr.
  if ((longint'(N_R) * longint'(N_C)) > (longint'(1) << ADDR_W)) begin : g_addr_width_check
    $error("maxpool_2x2_stage: ADDR_W too small for N_R*N_C");
  end

  if (((N_C % 2) != 0) || ((N_R % 2) != 0)) begin : g_even_dim_check
    $error("maxpool_2x2_stage: N_C and N_R must be even");
  end

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic               [1:0]   r_k;
  logic signed [DATA_W-1:0]   r_max;
  logic        [ADDR_W-1:0]   w_i;
  logic        [ADDR_W-1:0]   w_j;
  logic                       w_last;
  logic                       w_start_map;
  logic                       w_accept;
  logic        [ADDR_W-1:0]   w_row;
  logic        [ADDR_W-1:0]   w_col;
  logic        [ADDR_W-1:0]   w_fetch_addr;

  assign w_start_map = (r_state == S_IDLE) && start;
  assign w_accept    = (r_state == S_EMIT) && pool_ready;

  // k[1] selects the bottom row, k[0] the right column of the window.
  assign w_row        = (w_i << 1) + ADDR_W'(r_k[1]);
  assign w_col        = (w_j << 1) + ADDR_W'(r_k[0]);
  assign w_fetch_addr = (w_row * c_NC) + w_col;

  assign pool_data = r_max;
  assign pool_addr = (w_i * c_HALF_C) + w_j;

  pool_window_counter #(
    .N_C    (N_C),
    .N_R    (N_R),
    .ADDR_W (ADDR_W)
  ) u_window_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (w_start_map),
    .step  (w_accept),
    .i     (w_i),
    .j     (w_j),
    .last  (w_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_state_nxt = r_state;
    rd_addr     = '0;
    pool_valid  = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        rd_addr = w_fetch_addr;
        if (r_k == 2'd3) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        pool_valid = 1'b1;
        if (pool_ready) w_state_nxt = w_last ? S_FIN : S_FETCH;
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sub-index within the window; wraps 3->0 as FETCH hands over to DRAIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k <= '0;
    end else if (w_start_map) begin
      r_k <= '0;
    end else if (r_state == S_FETCH) begin
      r_k <= r_k + 2'd1;
    end
  end

  // Running max: read data lags the address by one cycle, so TL lands at
  // k=1, TR/BL at k=2/3 and BR in DRAIN; ties keep the held value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_max <= '0;
    end else if ((r_state == S_FETCH) && (r_k == 2'd1)) begin
      r_max <= rd_data;
    end else if (((r_state == S_FETCH) && r_k[1]) || (r_state == S_DRAIN)) begin
      if (rd_data > r_max) r_max <= rd_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maxpool_2x2_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_maxpool_2x2_stage                                   |
// | Brief   : Self-checking bench: feature memory model, window-max  |
// |           reference queue and per-cycle output comparison.       |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_maxpool_2x2_stage;

  localparam int NC   = 26;
  localparam int NR   = 26;
  localparam int DW   = 8;
  localparam int AW   = 10;
  localparam int NWIN = (NR / 2) * (NC / 2);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 pool_ready;
  logic        [AW-1:0] rd_addr;
  logic signed [DW-1:0] rd_data;
  logic signed [DW-1:0] pool_data;
  logic        [AW-1:0] pool_addr;
  logic                 pool_valid;
  logic                 busy;
  logic                 done;

  logic signed [DW-1:0] mem [0:NR*NC-1];
  int exp_data_q[$];
  int exp_addr_q[$];

  int checks      = 0;
  int errors      = 0;
  int out_count   = 0;
  int done_count  = 0;
  int valid_count = 0;
  int hold_len    = 0;
  int stall_n     = 0;
  int rdy_mode    = 0;
  int first_data  = 0;

  always #5 clk = ~clk;

  maxpool_2x2_stage dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pool_data  (pool_data),
    .pool_addr  (pool_addr),
    .pool_valid (pool_valid),
    .pool_ready (pool_ready),
    .busy       (busy),
    .done       (done)
  );

  // Feature memory with one-cycle read latency.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: max of each 2x2 block in raster order of pooled index.
  task automatic build_expected();
    exp_data_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < NR / 2; i++) begin
      for (int j = 0; j < NC / 2; j++) begin
        int m;
        int v;
        m = -1000;
        for (int r = 0; r < 2; r++) begin
          for (int c = 0; c < 2; c++) begin
            v = int'(mem[(2 * i + r) * NC + 2 * j + c]);
            if (v > m) m = v;
          end
        end
        exp_data_q.push_back(m);
        exp_addr_q.push_back(i * (NC / 2) + j);
      end
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < NR * NC; a++) mem[a] = DW'($urandom);
  endtask

  // Consumer ready: 0 = always, 1 = random, 2 = stall window 5 for 7 cycles.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: pool_ready = 1'b1;
      1: pool_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (pool_valid && (out_count == 5) && (stall_n < 7)) begin
          pool_ready = 1'b0;
          stall_n++;
        end else begin
          pool_ready = 1'b1;
        end
      end
    endcase
  end

  // Output comparison against the reference on every valid cycle.
  always @(negedge clk) begin
    if (!rst) begin
      hold_len = 0;
    end else begin
      if (pool_valid) begin
        valid_count++;
        hold_len++;
        check(rd_addr == '0, "rd_addr_in_emit", int'(rd_addr), 0);
        if (exp_data_q.size() == 0) begin
          check(1'b0, "unexpected_valid", int'(pool_addr), -1);
        end else begin
          check(int'(pool_data) == exp_data_q[0], "pool_data", int'(pool_data), exp_data_q[0]);
          check(int'(pool_addr) == exp_addr_q[0], "pool_addr", int'(pool_addr), exp_addr_q[0]);
          if (pool_ready) begin
            if (rdy_mode == 2 && exp_addr_q[0] == 5)
              check(hold_len == 8, "stall_hold_len", hold_len, 8);
            if (out_count == 0) first_data = int'(pool_data);
            void'(exp_data_q.pop_front());
            void'(exp_addr_q.pop_front());
          end
        end
        if (pool_ready) begin
          out_count++;
          hold_len = 0;
        end
      end
      if (done) done_count++;
    end
  end

  task automatic run_map(input int exp_cycles, input bit busy_start);
    int n;
    out_count  = 0;
    done_count = 0;
    stall_n    = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    while (!done && n < 20000) begin
      start = (busy_start && n == 300);
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check(done == 1'b1, "done_timeout", n, exp_cycles);
    if (exp_cycles > 0) check(n == exp_cycles, "done_cycle", n, exp_cycles);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check(busy == 1'b0, "busy_after_done", int'(busy), 0);
    check(done_count == 1, "done_pulses", done_count, 1);
    check(out_count == NWIN, "output_count", out_count, NWIN);
    check(exp_data_q.size() == 0, "windows_left", exp_data_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b0;
    start      = 1'b0;
    pool_ready = 1'b1;
    for (int a = 0; a < NR * NC; a++) mem[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    check(rd_addr == '0,     "reset_rd_addr",    int'(rd_addr), 0);
    check(pool_data == '0,   "reset_pool_data",  int'(pool_data), 0);
    check(pool_addr == '0,   "reset_pool_addr",  int'(pool_addr), 0);
    check(pool_valid == 1'b0, "reset_pool_valid", int'(pool_valid), 0);
    check(busy == 1'b0,      "reset_busy",       int'(busy), 0);
    check(done == 1'b0,      "reset_done",       int'(done), 0);
    rst = 1'b1;

    // Ramp map, ready tied high: exact done timing.
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) mem[r * NC + c] = DW'((r * NC + c) % 128);
    build_expected();
    check(exp_data_q[0] == 27, "model_ramp_w0", exp_data_q[0], 27);
    check(exp_data_q[NWIN-1] == 35, "model_ramp_wlast", exp_data_q[NWIN-1], 35);
    rdy_mode = 0;
    run_map(1015, 1'b0);
    check(first_data == 27, "ramp_first_output", first_data, 27);

    // Signed compare on window 0, random ready.
    fill_random();
    mem[0]      = -8'sd5;
    mem[1]      = -8'sd3;
    mem[NC]     = -8'sd128;
    mem[NC + 1] = -8'sd4;
    build_expected();
    check(exp_data_q[0] == -3, "model_signed_w0", exp_data_q[0], -3);
    rdy_mode = 1;
    run_map(0, 1'b0);
    check(first_data == -3, "signed_first_output", first_data, -3);

    // All pixels at the minimum value: every window ties.
    for (int a = 0; a < NR * NC; a++) mem[a] = -8'sd128;
    build_expected();
    check(exp_data_q[NWIN/2] == -128, "model_min_mid", exp_data_q[NWIN/2], -128);
    rdy_mode = 0;
    run_map(1015, 1'b0);
    check(first_data == -128, "min_first_output", first_data, -128);

    // Window 5 back-pressured for 7 cycles.
    fill_random();
    build_expected();
    rdy_mode = 2;
    run_map(1015 + 7, 1'b0);
    check(stall_n == 7, "stall_cycles_applied", stall_n, 7);

    // start pulsed while busy must be ignored.
    fill_random();
    build_expected();
    rdy_mode = 1;
    run_map(0, 1'b1);

    // Reset in the middle of window 40, then a fresh map.
    fill_random();
    build_expected();
    rdy_mode   = 0;
    out_count  = 0;
    done_count = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (out_count < 40 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(out_count == 40, "reach_window_40", out_count, 40);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    check(pool_valid == 1'b0, "midreset_valid", int'(pool_valid), 0);
    check(busy == 1'b0,       "midreset_busy",  int'(busy), 0);
    check(rd_addr == '0,      "midreset_rd_addr", int'(rd_addr), 0);
    check(pool_addr == '0,    "midreset_pool_addr", int'(pool_addr), 0);
    check(pool_data == '0,    "midreset_pool_data", int'(pool_data), 0);
    exp_data_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    valid_count = 0;
    done_count  = 0;
    repeat (10) @(posedge clk);
    #1;
    check(valid_count == 0, "no_valid_after_reset", valid_count, 0);
    check(done_count == 0,  "no_done_after_reset",  done_count, 0);
    build_expected();
    run_map(1015, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/maxpool_2x2_stage.md
MAXPOOL_2X2_STAGE -- requirements
Module: maxpool_2x2_stage

Interface
REQ-001 The block SHALL have parameter N_C, default 26, meaning feature-map columns (even).
REQ-002 The block SHALL have parameter N_R, default 26, meaning feature-map rows (even).
REQ-003 The block SHALL have parameter DATA_W, default 8, meaning signed pixel width.
REQ-004 The block SHALL have parameter ADDR_W, default 10, meaning feature-memory address width.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic runs on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1, meaning a one-cycle request to pool one full feature map.
REQ-008 The block SHALL have port rd_addr, output, ADDR_W, meaning the conv feature-memory read address, row*N_C+col.
REQ-009 The block SHALL have port rd_data, input, DATA_W, meaning the signed pixel returned exactly one cycle after rd_addr.
REQ-010 The block SHALL have port pool_data, output, DATA_W, meaning the signed 2x2 window maximum.
REQ-011 The block SHALL have port pool_addr, output, ADDR_W, meaning the pooled index i*(N_C/2)+j.
REQ-012 The block SHALL have port pool_valid, output, 1, meaning pool_data/pool_addr are valid.
REQ-013 The block SHALL have port pool_ready, input, 1, meaning the consumer accepts the result.
REQ-014 The block SHALL have ports busy, output, 1 (high outside IDLE) and done, output, 1 (one-cycle pulse at end of map).

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, DRAIN, EMIT, FIN.
REQ-016 IDLE->FETCH on start=1, with window counters i=0, j=0 and sub-index k=0; start outside IDLE SHALL be ignored.
REQ-017 FETCH: for 4 cycles, k=0..3, rd_addr SHALL be (2i+k[1])*N_C+2j+k[0], i.e. TL, TR, BL, BR; then ->DRAIN.
REQ-018 The running max SHALL be loaded unconditionally with the k=0 sample and replaced by each later sample only if signed-greater; ties SHALL keep the held value.
REQ-019 DRAIN SHALL take one cycle, fold in the k=3 sample, then ->EMIT.
REQ-020 EMIT SHALL hold pool_valid=1 with stable pool_data/pool_addr until pool_ready=1; pool_ready=1 on the first EMIT cycle SHALL give an accept in that cycle.
REQ-021 On accept: if j<N_C/2-1 then j++; else j=0 and i++. ->FETCH, unless (i,j) was (N_R/2-1, N_C/2-1), in which case ->FIN.
REQ-022 FIN SHALL assert done for exactly one cycle, then ->IDLE.
REQ-023 Per window latency with pool_ready tied high SHALL be 6 cycles; a full 26x26 map SHALL take 169*6+1=1015 cycles from the cycle after start to done.
REQ-024 pool_addr SHALL run 0..(N_R/2)*(N_C/2)-1 monotonically, with no gaps or repeats.
REQ-025 Address arithmetic SHALL be unsigned at ADDR_W bits; max rd_addr = N_R*N_C-1 SHALL fit ADDR_W (compile-time check).
REQ-026 rd_addr SHALL be 0 in IDLE, EMIT, FIN.

Reset
REQ-027 While rst=0: state=IDLE, i=j=k=0, rd_addr=0, pool_data=0, pool_addr=0, pool_valid=0, busy=0, done=0.
REQ-028 Reset asserted mid-map SHALL abandon the map; no pool_valid or done SHALL follow until a new start.
REQ-029 Reset release SHALL be synchronised by the integrator; the block SHALL take no action on the release cycle other than leaving reset.

Structure
REQ-030 A shared package SHALL hold N_C, N_R, DATA_W, ADDR_W defaults and the state enumeration.
REQ-031 A single sub-module pool_window_counter SHALL own i/j stepping and the last-window flag.
REQ-032 The comparator and running max SHALL live in the top level.

Verification
REQ-033 Ramp map pixel=(row*26+col) mod 128, pool_ready=1, start -> pool_data[0]=27, pool_addr sequence 0..168, done at cycle 1015.
REQ-034 Window 0 = {-5,-3,-128,-4} -> pool_data=-3 (signed compare).
REQ-035 All pixels = -128 -> all 169 outputs are -128 (tie and minimum path).
REQ-036 pool_ready low for 7 cycles on window 5 -> pool_valid held and data stable for 8 cycles; rd_addr=0 meanwhile; no window lost.
REQ-037 rst=0 during window 40, then start -> first output pool_addr=0 and exactly 169 outputs.
REQ-038 start pulsed while busy -> ignored; output count stays 169 and a single done pulse.
